// File: rtl/cb_pkg.sv
// Shared definitions for the LSP codebook search ROM: FSM states,
// Q15.16 format constants and the default codes4 table.
package cb_pkg;

    localparam int CB_N    = 32;
    localparam int CB_FRAC = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEARCH,
        DONE
    } cb_state_e;

    // codes4: 950.0 + 100.0*i in Q15.16
    localparam logic [31:0] CODES4 [16] = '{
        32'h03B6_0000, 32'h041A_0000, 32'h047E_0000, 32'h04E2_0000,
        32'h0546_0000, 32'h05AA_0000, 32'h060E_0000, 32'h0672_0000,
        32'h06D6_0000, 32'h073A_0000, 32'h079E_0000, 32'h0802_0000,
        32'h0866_0000, 32'h08CA_0000, 32'h092E_0000, 32'h0992_0000
    };

endpackage

// File: rtl/cb_rom_core.sv
// DEPTH x N codebook array with a combinational read port,
// loaded from the built-in codes4 table.
module cb_rom_core
    import cb_pkg::*;
#(
    parameter int N         = CB_N,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter     INIT_FILE = ""
) (
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  data
);

    logic [N-1:0] mem [DEPTH];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            if (g < 16) begin : g_tab
                assign mem[g] = N'(CODES4[g]);
            end else begin : g_zero
                assign mem[g] = '0;
            end
        end
    endgenerate

    assign data = mem[addr];

endmodule

// File: rtl/cb_search_rom.sv
// Codebook store with registered single-entry read and a sequential
// nearest-entry search returning index, absolute error and value.
module cb_search_rom
    import cb_pkg::*;
#(
    parameter int N         = CB_N,
    parameter int FRAC      = CB_FRAC,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_cb,
    input  logic          mode,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  target,
    output logic [N-1:0]  dataout,
    output logic [AW-1:0] best_index,
    output logic [N-1:0]  best_error,
    output logic          busy,
    output logic          done_cb
);

    generate
        if (FRAC >= N || DEPTH < 2 || DEPTH > (1 << AW)) begin : g_bad_cfg
            $error("cb_search_rom: bad FRAC/DEPTH/AW combination");
        end
    endgenerate

    cb_state_e state, state_n;

    logic [AW-1:0] addr_q;
    logic [AW-1:0] idx;
    logic [N-1:0]  target_q;
    logic [N-1:0]  acc_err;
    logic [N-1:0]  acc_val;
    logic [AW-1:0] acc_idx;

    logic [AW-1:0] rom_addr;
    logic [N-1:0]  rom_data;
    logic [N:0]    diff;
    logic [N:0]    neg;
    logic [N-1:0]  err;
    logic          better;
    logic          last;
    logic          accept;

    cb_rom_core #(
        .N         (N),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    assign accept   = (state == IDLE) && start_cb;
    assign rom_addr = (state == SEARCH) ? idx : addr_q;

    // One extra bit so the signed difference cannot overflow
    assign diff   = {target_q[N-1], target_q} - {rom_data[N-1], rom_data};
    assign neg    = -diff;
    assign err    = diff[N] ? neg[N-1:0] : diff[N-1:0];
    assign better = err < acc_err;
    assign last   = (idx == AW'(DEPTH - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_cb) state_n = mode ? SEARCH : READ;
            READ:    state_n = DONE;
            SEARCH:  if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            target_q   <= '0;
            idx        <= '0;
            acc_err    <= '0;
            acc_idx    <= '0;
            acc_val    <= '0;
            dataout    <= '0;
            best_index <= '0;
            best_error <= '0;
            busy       <= 1'b0;
            done_cb    <= 1'b0;
        end else begin
            busy    <= (state_n != IDLE);
            done_cb <= (state_n == DONE);
            if (accept) begin
                addr_q   <= addr;
                target_q <= target;
                idx      <= '0;
                acc_err  <= '1;
                acc_idx  <= '0;
                acc_val  <= '0;
            end
            if (state == READ) dataout <= rom_data;
            if (state == SEARCH) begin
                if (!last) idx <= idx + 1'b1;
                if (better) begin
                    acc_err <= err;
                    acc_idx <= idx;
                    acc_val <= rom_data;
                end
                // Publish only at the end so outputs hold during a scan
                if (last) begin
                    best_error <= better ? err      : acc_err;
                    best_index <= better ? idx      : acc_idx;
                    dataout    <= better ? rom_data : acc_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_cb_search_rom.sv
// Directed self-checking bench for cb_search_rom with the default
// codes4 table (950.0 + 100.0*i, Q15.16).
module tb_cb_search_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_cb = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] target = '0;
    logic [31:0] dataout;
    logic [3:0]  best_index;
    logic [31:0] best_error;
    logic        busy;
    logic        done_cb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb_search_rom dut (
        .clk        (clk),
        .rst        (rst),
        .start_cb   (start_cb),
        .mode       (mode),
        .addr       (addr),
        .target     (target),
        .dataout    (dataout),
        .best_index (best_index),
        .best_error (best_error),
        .busy       (busy),
        .done_cb    (done_cb)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Start an operation and watch 30 cycles for done_cb.
    task automatic run(input logic m, input logic [3:0] a,
                       input logic [31:0] t, input bit overlap,
                       output int lat, output int ndone,
                       output logic busy1);
        @(negedge clk);
        start_cb = 1'b1;
        mode     = m;
        addr     = a;
        target   = t;
        @(negedge clk);
        start_cb = 1'b0;
        lat   = 0;
        ndone = 0;
        busy1 = busy;
        for (int k = 1; k <= 30; k++) begin
            if (done_cb) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            start_cb = overlap && (k == 3 || k == 8 || k == 16);
            mode     = 1'b0;
            @(negedge clk);
        end
        start_cb = 1'b0;
    endtask

    int   lat, nd;
    logic b1;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", dataout, 32'h0);
        check("rst_idx", 32'(best_index), 32'h0);
        check("rst_err", best_error, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done_cb), 32'h0);
        rst = 1'b0;

        run(1'b0, 4'd11, 32'h0, 1'b0, lat, nd, b1);
        check("rd_data", dataout, 32'h0802_0000);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_ndone", 32'(nd), 32'd1);
        check("rd_busy1", 32'(b1), 32'd1);
        check("rd_idx", 32'(best_index), 32'h0);
        check("rd_err", best_error, 32'h0);

        run(1'b1, 4'd0, 32'h055F_0000, 1'b0, lat, nd, b1);
        check("s1375_idx", 32'(best_index), 32'd4);
        check("s1375_err", best_error, 32'h0019_0000);
        check("s1375_data", dataout, 32'h0546_0000);
        check("s1375_lat", 32'(lat), 32'd17);
        check("s1375_busyend", 32'(busy), 32'd0);

        run(1'b0, 4'd11, 32'h0, 1'b0, lat, nd, b1);
        check("rd2_data", dataout, 32'h0802_0000);
        check("rd2_idx", 32'(best_index), 32'd4);
        check("rd2_err", best_error, 32'h0019_0000);

        run(1'b1, 4'd0, 32'h0578_0000, 1'b0, lat, nd, b1);
        check("tie_idx", 32'(best_index), 32'd4);
        check("tie_err", best_error, 32'h0032_0000);

        run(1'b1, 4'd0, 32'hFF9C_0000, 1'b0, lat, nd, b1);
        check("neg_idx", 32'(best_index), 32'd0);
        check("neg_err", best_error, 32'h041A_0000);
        check("neg_data", dataout, 32'h03B6_0000);

        run(1'b1, 4'd0, 32'h0BB8_0000, 1'b0, lat, nd, b1);
        check("hi_idx", 32'(best_index), 32'd15);
        check("hi_err", best_error, 32'h0226_0000);
        check("hi_data", dataout, 32'h0992_0000);

        run(1'b1, 4'd0, 32'h055F_0000, 1'b1, lat, nd, b1);
        check("ovl_ndone", 32'(nd), 32'd1);
        check("ovl_lat", 32'(lat), 32'd17);
        check("ovl_idx", 32'(best_index), 32'd4);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_data", dataout, 32'h0);
        check("arst_idx", 32'(best_index), 32'h0);
        check("arst_err", best_error, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Abort a scan at t+8
        @(negedge clk);
        start_cb = 1'b1;
        mode     = 1'b1;
        target   = 32'h0BB8_0000;
        @(negedge clk);
        start_cb = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idx", 32'(best_index), 32'd0);
        check("abort_data", dataout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            if (done_cb) nd++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(nd), 32'd0);

        run(1'b1, 4'd0, 32'hFF9C_0000, 1'b0, lat, nd, b1);
        check("fresh_idx", 32'(best_index), 32'd0);
        check("fresh_err", best_error, 32'h041A_0000);
        check("fresh_lat", 32'(lat), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_search_rom.md
# cb_search_rom

Parametrised LSP codebook store with a built-in nearest-entry search engine, used by the 2400 bit/s encoder's codebook-select stage. Holds DEPTH fixed-point entries (two's complement Q15.16, 1 sign + 15 integer + 16 fraction bits). Offers two modes: a registered single-entry read, and a sequential scan that returns the index and absolute error of the entry closest to a supplied target. Replaces per-codebook combinational ROMs plus external compare logic with one reusable block per codebook.

## Interface
- N, 32, data width in bits (Q format, FRAC fraction bits)
- FRAC, 16, fraction bits
- DEPTH, 16, number of valid entries (2..2^AW)
- AW, 4, address/index width
- INIT_FILE, "", binary init file for $readmemb; empty selects built-in default table codes4 (950.0 + 100.0·i, i=0..15)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_cb  in  1  single-cycle request; sampled only in IDLE
- mode  in  1  0 = read, 1 = search; sampled with start_cb
- addr  in  AW  read address; sampled with start_cb
- target  in  N  search target, signed Q15.16; sampled with start_cb
- dataout  out  N  read result, or codebook value of best entry after search
- best_index  out  AW  index of nearest entry (search mode)
- best_error  out  N  unsigned |target − cb[best_index]|, Q16.16
- busy  out  1  high from cycle after accepted start until done_cb cycle inclusive
- done_cb  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, READ, SEARCH, DONE.
- IDLE: start_cb=1 latches mode/addr/target; mode 0 → READ, mode 1 → SEARCH with scan index i=0, best_error=all-ones, best_index=0.
- READ: dataout ← cb[addr]; → DONE. best_index/best_error unchanged.
- SEARCH: each cycle compute d = target − cb[i] in N+1 bits, e = |d| (fits N bits unsigned); if e < best_error (strict) update best_error, best_index=i, dataout=cb[i]. Ties keep the lower index. After i = DEPTH−1 → DONE; i never addresses entries ≥ DEPTH.
- DONE: done_cb=1 for one cycle → IDLE. Outputs hold until the next completion overwrites them.
- start_cb while busy is ignored (not queued).
- Reset (any time, including mid-scan): state IDLE, dataout/best_index/best_error/busy/done_cb = 0; no done_cb for the aborted operation.

## Timing
- Start accepted at edge t.
- Read: dataout valid and done_cb high in cycle t+2 (READ at t+1, DONE at t+2).
- Search: entries evaluated in cycles t+1..t+DEPTH; done_cb high at t+DEPTH+1 (t+17 at defaults).
- Earliest next start accepted in the cycle after done_cb.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package cb_pkg: FSM state encoding, Q-format constants (N, FRAC), default codes4 table as a constant array.
- Sub-module cb_rom_core: DEPTH×N array with INIT_FILE / default loading and a combinational read port. Instantiated once; the FSM, subtract/abs/compare datapath and output registers live in the top.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately, busy 0.
- Read addr=11 → dataout 0x08020000 (2050.0), done_cb at t+2, best_index/best_error unchanged.
- Search target 0x055F0000 (1375.0) → best_index 4, best_error 0x00190000 (25.0), dataout 0x05460000, done_cb at t+17.
- Tie: target 0x05780000 (1400.0) → best_index 4 (lower index wins), best_error 0x00320000.
- Edges: target 0xFF9C0000 (−100.0) → index 0, error 0x041A0000; target 0x0BB80000 (3000.0) → index 15, error 0x02260000.
- Abort and overlap: start_cb pulses during search ignored (single done_cb at t+17); rst at t+8 of search → outputs 0, no done_cb; a fresh search afterwards completes normally.
